// File: rtl/csa_array_if.sv
// csa_array_if: bundles the per-channel signals of the CSA bank.
//   charge_in_r       : charge (C) deposited on each channel this cycle
//   csa_enable        : per-channel enable
//   csa_reset         : per-channel level-sensitive reset request
//   gain_sel          : 0 = high gain (small Cfb), 1 = low gain (large Cfb)
//   periodic_reset_en : enables the periodic reset timer
//   csa_vout_r        : per-channel output voltage (V)
//   csa_saturated     : channel clamped at a rail
//   csa_in_reset      : channel in reset hold
// master drives the inputs (testbench / analog_core), slave is the CSA bank.
interface csa_array_if #(
  parameter int unsigned NUM_CHANNELS = 8
);
  real                     charge_in_r [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] csa_enable;
  logic [NUM_CHANNELS-1:0] csa_reset;
  logic                    gain_sel;
  logic                    periodic_reset_en;
  real                     csa_vout_r  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] csa_saturated;
  logic [NUM_CHANNELS-1:0] csa_in_reset;

  modport master (
    output charge_in_r, csa_enable, csa_reset, gain_sel, periodic_reset_en,
    input  csa_vout_r, csa_saturated, csa_in_reset
  );

  modport slave (
    input  charge_in_r, csa_enable, csa_reset, gain_sel, periodic_reset_en,
    output csa_vout_r, csa_saturated, csa_in_reset
  );
endinterface

// File: rtl/csa_array.sv
// csa_array: clocked behavioural model of a bank of charge-sensitive amplifiers.
// Each channel integrates the per-cycle input charge onto a selectable
// feedback capacitor (inverting), with optional leakage toward VOUT_DC, rail
// saturation, a minimum-length reset hold, and an optional periodic reset.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset of every channel and the timer
//   bus   : csa_array_if.slave carrying the per-channel inputs and the
//           registered outputs (csa_vout_r, csa_saturated, csa_in_reset)
module csa_array #(
  parameter int unsigned NUM_CHANNELS          = 8,
  parameter real         CFB_HIGH_GAIN         = 40e-15,
  parameter real         CFB_LOW_GAIN          = 80e-15,
  parameter real         VOUT_DC               = 0.5,
  parameter real         VOUT_MAX              = 1.8,
  parameter real         VOUT_MIN              = 0.0,
  parameter real         LEAK_FRAC             = 0.0,
  parameter int unsigned RESET_CYCLES          = 4,
  parameter int unsigned PERIODIC_RESET_PERIOD = 0
) (
  input  logic          clk,
  input  logic          reset,
  csa_array_if.slave    bus
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [31:0] PER_LAST =
    (PERIODIC_RESET_PERIOD == 0) ? '0 : 32'(PERIODIC_RESET_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAT    = 2'd2
  } ch_state_e;

  ch_state_e         state_q [NUM_CHANNELS];
  ch_state_e         state_d [NUM_CHANNELS];
  logic [HOLD_W-1:0] hold_q  [NUM_CHANNELS];
  logic [HOLD_W-1:0] hold_d  [NUM_CHANNELS];
  real               vout_q  [NUM_CHANNELS];
  real               vout_d  [NUM_CHANNELS];
  logic [31:0]       per_cnt_q;
  logic [31:0]       per_cnt_d;
  logic              tick;
  real               cfb;
  real               v_new;

  // Periodic timer: counts 0..PERIOD-1, ticks on the terminal count.
  always_comb begin
    tick      = 1'b0;
    per_cnt_d = '0;
    if (bus.periodic_reset_en && (PERIODIC_RESET_PERIOD > 0)) begin
      if (per_cnt_q == PER_LAST) begin
        tick      = 1'b1;
        per_cnt_d = '0;
      end else begin
        per_cnt_d = per_cnt_q + 32'd1;
      end
    end
  end

  // Per-channel next state. Priority: disable > reset trigger > state update.
  // A trigger while already holding reloads the counter, so a held request
  // keeps the channel in hold and the pulse is never shorter than RESET_CYCLES.
  always_comb begin
    cfb   = bus.gain_sel ? CFB_LOW_GAIN : CFB_HIGH_GAIN;
    v_new = 0.0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
      vout_d[i]  = vout_q[i];
      if (!bus.csa_enable[i]) begin
        state_d[i] = ST_ACTIVE;
        hold_d[i]  = '0;
        vout_d[i]  = VOUT_DC;
      end else if (bus.csa_reset[i] || tick) begin
        state_d[i] = ST_HOLD;
        hold_d[i]  = HOLD_LOAD;
        vout_d[i]  = VOUT_DC;
      end else begin
        case (state_q[i])
          ST_ACTIVE: begin
            v_new = vout_q[i] - bus.charge_in_r[i] / cfb
                    - LEAK_FRAC * (vout_q[i] - VOUT_DC);
            if (v_new > VOUT_MAX) begin
              vout_d[i]  = VOUT_MAX;
              state_d[i] = ST_SAT;
            end else if (v_new < VOUT_MIN) begin
              vout_d[i]  = VOUT_MIN;
              state_d[i] = ST_SAT;
            end else begin
              vout_d[i] = v_new;
            end
          end
          ST_HOLD: begin
            vout_d[i] = VOUT_DC;
            if (hold_q[i] != '0) begin
              hold_d[i] = hold_q[i] - 1'b1;
            end else begin
              state_d[i] = ST_ACTIVE;
            end
          end
          ST_SAT: begin
            vout_d[i] = vout_q[i];
          end
          default: begin
            state_d[i] = ST_ACTIVE;
            hold_d[i]  = '0;
            vout_d[i]  = VOUT_DC;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= ST_ACTIVE;
        hold_q[i]  <= '0;
        vout_q[i]  <= VOUT_DC;
      end
    end else begin
      per_cnt_q <= per_cnt_d;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        hold_q[i]  <= hold_d[i];
        vout_q[i]  <= vout_d[i];
      end
    end
  end

  // Flags decode directly from the registered state, so they stay registered.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      bus.csa_vout_r[i]    = vout_q[i];
      bus.csa_saturated[i] = (state_q[i] == ST_SAT);
      bus.csa_in_reset[i]  = (state_q[i] == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_csa_array.sv
// tb_csa_array: directed checks of csa_array. A default instance runs a table
// of single-edge vectors on channel 0; a leaky instance and a periodic-reset
// instance are exercised with short hand-written sequences.
module tb_csa_array;

  localparam int unsigned N = 8;
  localparam real TOL = 1e-9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  csa_array_if #(.NUM_CHANNELS(N)) bus_b ();
  csa_array_if #(.NUM_CHANNELS(N)) bus_l ();
  csa_array_if #(.NUM_CHANNELS(N)) bus_p ();

  csa_array #(.NUM_CHANNELS(N)) u_base (
    .clk(clk), .reset(reset), .bus(bus_b)
  );
  csa_array #(.NUM_CHANNELS(N), .LEAK_FRAC(0.5)) u_leak (
    .clk(clk), .reset(reset), .bus(bus_l)
  );
  csa_array #(.NUM_CHANNELS(N), .PERIODIC_RESET_PERIOD(10)) u_per (
    .clk(clk), .reset(reset), .bus(bus_p)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic grst;
    real  chg;
    logic gain;
    logic crst;
    logic en;
    real  exp_v;
    logic exp_sat;
    logic exp_inr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic grst, input real chg, input logic gain,
                     input logic crst, input logic en, input real exp_v,
                     input logic exp_sat, input logic exp_inr);
    vec_t v;
    v.grst = grst; v.chg = chg; v.gain = gain; v.crst = crst; v.en = en;
    v.exp_v = exp_v; v.exp_sat = exp_sat; v.exp_inr = exp_inr;
    vecs.push_back(v);
  endtask

  task automatic chk_r(input string name, input real act, input real exp_v);
    n_total++;
    if ((act - exp_v < TOL) && (exp_v - act < TOL)) n_pass++;
    else $display("FAIL %s: got %f expected %f", name, act, exp_v);
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp_b);
    n_total++;
    if (act === exp_b) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp_b);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_charges();
    for (int i = 0; i < N; i++) begin
      bus_b.charge_in_r[i] = 0.0;
      bus_l.charge_in_r[i] = 0.0;
      bus_p.charge_in_r[i] = 0.0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_charges();
    bus_b.csa_enable = '1; bus_b.csa_reset = '0; bus_b.gain_sel = 1'b0;
    bus_b.periodic_reset_en = 1'b0;
    bus_l.csa_enable = '1; bus_l.csa_reset = '0; bus_l.gain_sel = 1'b0;
    bus_l.periodic_reset_en = 1'b0;
    bus_p.csa_enable = '1; bus_p.csa_reset = '0; bus_p.gain_sel = 1'b0;
    bus_p.periodic_reset_en = 1'b0;
    #2;
    step();
    step();
    reset = 1'b0;

    for (int i = 0; i < N; i++) begin
      chk_r($sformatf("rst_vout[%0d]", i), bus_b.csa_vout_r[i], 0.5);
      chk_b($sformatf("rst_sat[%0d]", i), bus_b.csa_saturated[i], 1'b0);
      chk_b($sformatf("rst_inr[%0d]", i), bus_b.csa_in_reset[i], 1'b0);
    end

    //  grst chg      gain crst en   exp_v sat inr
    add(0, -4e-15,  0, 0, 1, 0.6,  0, 0);  // high gain: +0.1 V
    add(0,  0.0,    0, 0, 1, 0.6,  0, 0);
    add(0,  0.0,    0, 0, 1, 0.6,  0, 0);
    add(1,  0.0,    0, 0, 1, 0.5,  0, 0);
    add(0, -4e-15,  1, 0, 1, 0.55, 0, 0);  // low gain: +0.05 V
    add(0,  0.0,    0, 0, 1, 0.55, 0, 0);  // gain switch, no rescale
    add(1,  0.0,    0, 0, 1, 0.5,  0, 0);
    add(0, -60e-15, 0, 0, 1, 1.8,  1, 0);  // 2.0 V clamps at top rail
    add(0,  40e-15, 0, 0, 1, 1.8,  1, 0);  // saturated ignores charge
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);  // one-cycle reset pulse
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 0);  // hold lasted exactly 4 cycles
    add(0, -8e-15,  0, 1, 1, 0.5,  0, 1);  // charge in entry cycle lost
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0, -4e-15,  0, 0, 0, 0.5,  0, 0);  // disable mid-hold
    add(0, -4e-15,  0, 0, 1, 0.6,  0, 0);  // re-enabled, ACTIVE from 0.5
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);
    add(1,  0.0,    0, 0, 1, 0.5,  0, 0);  // global reset mid-hold
    add(0, -4e-15,  0, 0, 1, 0.6,  0, 0);
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);  // held request, 6 edges
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 1, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 1);
    add(0,  0.0,    0, 0, 1, 0.5,  0, 0);
    add(0,  60e-15, 0, 0, 1, 0.0,  1, 0);  // -1.0 V clamps at bottom rail
    add(0,  0.0,    0, 0, 0, 0.5,  0, 0);  // disable exits saturation
    add(0,  0.0,    0, 0, 1, 0.5,  0, 0);

    foreach (vecs[k]) begin
      reset                 = vecs[k].grst;
      bus_b.charge_in_r[0]  = vecs[k].chg;
      bus_b.gain_sel        = vecs[k].gain;
      bus_b.csa_reset[0]    = vecs[k].crst;
      bus_b.csa_enable[0]   = vecs[k].en;
      step();
      chk_r($sformatf("vec%0d_vout0", k), bus_b.csa_vout_r[0], vecs[k].exp_v);
      chk_b($sformatf("vec%0d_sat0", k), bus_b.csa_saturated[0], vecs[k].exp_sat);
      chk_b($sformatf("vec%0d_inr0", k), bus_b.csa_in_reset[0], vecs[k].exp_inr);
      chk_r($sformatf("vec%0d_vout7", k), bus_b.csa_vout_r[7], 0.5);
    end
    reset = 1'b0;
    bus_b.charge_in_r[0] = 0.0;
    bus_b.csa_reset = '0;
    bus_b.csa_enable = '1;

    // Leakage: half of the excess above VOUT_DC removed each cycle.
    bus_l.charge_in_r[0] = -4e-15;
    step();
    chk_r("leak_0", bus_l.csa_vout_r[0], 0.6);
    bus_l.charge_in_r[0] = 0.0;
    step();
    chk_r("leak_1", bus_l.csa_vout_r[0], 0.55);
    step();
    chk_r("leak_2", bus_l.csa_vout_r[0], 0.525);
    step();
    chk_r("leak_3", bus_l.csa_vout_r[0], 0.5125);

    // Periodic reset, period 10, channel 2 disabled.
    bus_p.csa_enable = 8'hFB;
    for (int i = 0; i < N; i++) bus_p.charge_in_r[i] = -8e-15;
    step();
    chk_r("per_pre_v0", bus_p.csa_vout_r[0], 0.7);
    chk_r("per_pre_v5", bus_p.csa_vout_r[5], 0.7);
    chk_r("per_pre_v2", bus_p.csa_vout_r[2], 0.5);
    for (int i = 0; i < N; i++) bus_p.charge_in_r[i] = 0.0;
    bus_p.periodic_reset_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_b($sformatf("per_e%0d_inr0", k), bus_p.csa_in_reset[0], 1'b0);
    end
    chk_r("per_e9_v0", bus_p.csa_vout_r[0], 0.7);
    step();  // edge 10: tick
    chk_r("per_e10_v0", bus_p.csa_vout_r[0], 0.5);
    chk_r("per_e10_v7", bus_p.csa_vout_r[7], 0.5);
    chk_b("per_e10_inr0", bus_p.csa_in_reset[0], 1'b1);
    chk_b("per_e10_inr1", bus_p.csa_in_reset[1], 1'b1);
    chk_b("per_e10_inr7", bus_p.csa_in_reset[7], 1'b1);
    chk_b("per_e10_inr2", bus_p.csa_in_reset[2], 1'b0);
    for (int k = 11; k <= 13; k++) begin
      step();
      chk_b($sformatf("per_e%0d_inr0", k), bus_p.csa_in_reset[0], 1'b1);
    end
    step();  // edge 14
    chk_b("per_e14_inr0", bus_p.csa_in_reset[0], 1'b0);
    bus_p.charge_in_r[0] = -8e-15;
    step();  // edge 15
    bus_p.charge_in_r[0] = 0.0;
    chk_r("per_e15_v0", bus_p.csa_vout_r[0], 0.7);
    for (int k = 16; k <= 19; k++) step();
    chk_b("per_e19_inr0", bus_p.csa_in_reset[0], 1'b0);
    chk_r("per_e19_v0", bus_p.csa_vout_r[0], 0.7);
    step();  // edge 20: second tick
    chk_b("per_e20_inr0", bus_p.csa_in_reset[0], 1'b1);
    chk_r("per_e20_v0", bus_p.csa_vout_r[0], 0.5);
    chk_b("per_e20_inr2", bus_p.csa_in_reset[2], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/csa_array.md
Name: csa_array

Overview:
- Clocked, multi-channel behavioural model of the charge-sensitive amplifier bank, used in the analog_core testbench.
- Each channel integrates the charge deposited per clock onto a selectable feedback capacitor.
- Channels also model leakage droop toward the DC level, rail saturation, a multi-cycle reset hold, and an optional periodic global reset.
- Outputs are real-valued voltages that feed the downstream discriminator/ADC models.

Parameters:
- NUM_CHANNELS, 8: number of independent CSA channels.
- CFB_HIGH_GAIN, 40e-15: feedback capacitance (F) when gain_sel=0.
- CFB_LOW_GAIN, 80e-15: feedback capacitance (F) when gain_sel=1.
- VOUT_DC, 0.5: baseline/reset output voltage (V).
- VOUT_MAX, 1.8: upper output rail (V).
- VOUT_MIN, 0.0: lower output rail (V).
- LEAK_FRAC, 0.0: fraction of (vout - VOUT_DC) removed per clock, range 0.0 to 1.0.
- RESET_CYCLES, 4: minimum number of cycles a channel is held in reset, must be ≥1.
- PERIODIC_RESET_PERIOD, 0: cycles between periodic resets; 0 disables the feature.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- charge_in_r  input  real[NUM_CHANNELS]  charge (C) deposited on each channel input during the current cycle.
- csa_enable  input  [NUM_CHANNELS-1:0]  per-channel enable.
- csa_reset  input  [NUM_CHANNELS-1:0]  per-channel reset request, level sensitive.
- gain_sel  input  1  0 selects high gain (CFB_HIGH_GAIN), 1 selects low gain (CFB_LOW_GAIN).
- periodic_reset_en  input  1  enables the periodic reset timer.
- csa_vout_r  output  real[NUM_CHANNELS]  CSA output voltage.
- csa_saturated  output  [NUM_CHANNELS-1:0]  channel is clamped at a rail.
- csa_in_reset  output  [NUM_CHANNELS-1:0]  channel is in reset hold.

Behaviour:
- All state updates occur on the rising edge of clk. Outputs are registered.
- Charge sampled at edge n is reflected in csa_vout_r immediately after edge n.
- reset=1 forces, for every channel:
  - csa_vout_r = VOUT_DC
  - state = ACTIVE
  - csa_saturated = 0, csa_in_reset = 0
  - hold counter = 0
- reset=1 also clears the periodic counter to 0.
- reset overrides all other inputs, including mid-hold and mid-saturation.
- Per-channel states: ACTIVE, RESET_HOLD, SATURATED.
- ACTIVE update (charge is negative for electrons; the CSA is inverting):
  - v = vout - charge_in_r/Cfb - LEAK_FRAC*(vout - VOUT_DC)
  - If v > VOUT_MAX: vout = VOUT_MAX, go to SATURATED.
  - If v < VOUT_MIN: vout = VOUT_MIN, go to SATURATED.
  - Otherwise vout = v.
- Cfb is selected by gain_sel on the same edge. Changing gain never rescales the stored voltage.
- Entering RESET_HOLD (from any state):
  - Triggers: csa_reset[i]=1, or a periodic tick.
  - Actions: vout = VOUT_DC, csa_saturated = 0, hold counter = RESET_CYCLES-1, csa_in_reset = 1.
  - Charge arriving in the entry cycle is discarded.
- RESET_HOLD:
  - vout is held at VOUT_DC and all charge is discarded.
  - The counter decrements to 0 and then stops.
  - Exit to ACTIVE on the edge where counter==0 and csa_reset[i]==0; csa_in_reset falls on that edge.
  - Result: the minimum csa_in_reset pulse is RESET_CYCLES cycles. A held csa_reset extends the hold indefinitely.
- SATURATED:
  - vout is held at the rail; charge and leakage are ignored; csa_saturated = 1.
  - The only exits are a reset trigger or disable.
- Periodic timer:
  - Active only when periodic_reset_en=1 and PERIODIC_RESET_PERIOD>0.
  - Counts 0 to PERIOD-1. A tick occurs on the edge where the count equals PERIOD-1, and the count then wraps to 0.
  - The tick resets every enabled channel simultaneously.
  - periodic_reset_en=0 clears the count to 0.
- Disabled channel (csa_enable[i]=0):
  - vout = VOUT_DC, state = ACTIVE, flags = 0, counter = 0.
  - Charge is ignored, reset requests are ignored, and the channel is not affected by ticks.
  - Disable takes precedence over reset hold and saturation.
  - On re-enable, the channel resumes in ACTIVE from VOUT_DC.
- Precedence: global reset > disable > reset trigger (csa_reset or tick) > saturation/integration.
- Channels are fully independent apart from gain_sel and the periodic tick.

Test Plan:
- reset, all enabled, gain_sel=0, charge_in_r[0] = -4e-15 for one cycle -> csa_vout_r[0]=0.6 after that edge and holds at 0.6; other channels stay at 0.5.
- Same stimulus with gain_sel=1 -> csa_vout_r[0]=0.55. Then switch gain_sel to 0 with no charge -> output stays at 0.55 (no rescale).
- Saturation at gain_sel=0: charge -60e-15 -> vout=1.8, csa_saturated[0]=1; further charge of +40e-15 leaves vout at 1.8. Then csa_reset pulsed for 1 cycle -> vout=0.5, csa_in_reset high for exactly 4 cycles, csa_saturated=0.
- LEAK_FRAC=0.5: deposit -4e-15 (vout 0.6), then zero charge -> successive outputs 0.55, 0.525, 0.5125.
- PERIODIC_RESET_PERIOD=10, periodic_reset_en=1, channel 2 disabled, all channels at 0.7 -> at the 10th edge channels 0,1,3–7 return to 0.5 with csa_in_reset asserted; channel 2 is unaffected; the next tick follows 10 cycles later.
- Simultaneous and mid-operation events:
  - csa_reset[1] asserted in the same cycle as charge -8e-15 -> vout stays at 0.5 and the charge is lost.
  - Global reset asserted during a hold -> csa_in_reset clears on the next edge.
  - csa_enable dropped during a hold -> flags clear and the channel returns to ACTIVE at 0.5.
